cpu_mul_arbiter: RTL and testbench

- Shares one 32x32 low-word multiplier cell between two requesters, e.g. CPU ALU port and a DMA/DSP helper port.
- Round-robin arbitration, one issue per clock, fully pipelined.
- Tracks each issued operation through the cell's fixed latency and returns the product to the requester that issued it.
- Sits between the requesters and the multiplier cell instance. The cell is external, wired through the A_mul_* ports.

---
 rtl/cpu_mul_pkg.sv | 23 ++
 rtl/cpu_mul_tag_pipe.sv | 52 +++++
 rtl/cpu_mul_arbiter.sv | 108 ++++++++++
 tb/tb_cpu_mul_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mul_pkg.sv
// Shared definitions for the two-requester multiplier arbiter.
package cpu_mul_pkg;

    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned ID_W            = 1;
    localparam int unsigned MUL_LATENCY_MIN = 1;
    localparam int unsigned MUL_LATENCY_MAX = 4;

    typedef logic [ID_W-1:0] req_id_t;

    // Requester that most recently won the cell.
    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } last_grant_e;

    // One in-flight operation: occupied flag and owning requester.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } mul_tag_t;

endpackage

// File: rtl/cpu_mul_tag_pipe.sv
// Depth-DEPTH shift register of {valid, id} tags that tracks operations
// through the multiplier cell's fixed latency.
module cpu_mul_tag_pipe
    import cpu_mul_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    output logic            any_valid
);

    mul_tag_t stage_q [DEPTH];
    mul_tag_t stage_d [DEPTH];

    // Stage 0 captures the issue every clock; later stages shift along.
    always_comb begin
        stage_d[0] = '{valid: in_valid, id: in_id};
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Tag registers; reset drops every in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    // Any occupied stage means work is still in flight.
    always_comb begin
        any_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage_q[i].valid;
        end
    end

    assign out_valid = stage_q[DEPTH-1].valid;
    assign out_id    = stage_q[DEPTH-1].id;

endmodule

// File: rtl/cpu_mul_arbiter.sv
// Round-robin sharing of one pipelined multiplier cell between two
// requesters; results are steered back to the issuer after MUL_LATENCY.
module cpu_mul_arbiter
    import cpu_mul_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 1,
    parameter int unsigned DATA_W      = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,
    output logic [DATA_W-1:0] A_mul_src1,
    output logic [DATA_W-1:0] A_mul_src2,
    input  logic [DATA_W-1:0] A_mul_cell_result,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_result,
    output logic              busy
);

    last_grant_e     last_grant_q;
    last_grant_e     last_grant_d;
    logic            grant0;
    logic            grant1;
    logic            tag_out_valid;
    logic [ID_W-1:0] tag_out_id;
    logic            tag_any_valid;

    // Round-robin pick: on contention the requester that did not win last.
    always_comb begin
        grant0       = 1'b0;
        grant1       = 1'b0;
        last_grant_d = last_grant_q;
        if (req0_valid && req1_valid) begin
            if (last_grant_q == GRANT_REQ1) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else if (req0_valid) begin
            grant0 = 1'b1;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
        if (grant0) begin
            last_grant_d = GRANT_REQ0;
        end else if (grant1) begin
            last_grant_d = GRANT_REQ1;
        end
    end

    // Fairness state; reset favours requester 0 on the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= GRANT_REQ1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Operand mux to the cell; idle cycles drive zero.
    always_comb begin
        A_mul_src1 = '0;
        A_mul_src2 = '0;
        if (grant0) begin
            A_mul_src1 = req0_src1;
            A_mul_src2 = req0_src2;
        end else if (grant1) begin
            A_mul_src1 = req1_src1;
            A_mul_src2 = req1_src2;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    cpu_mul_tag_pipe #(
        .DEPTH (MUL_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (reset_n),
        .in_valid  (grant0 | grant1),
        .in_id     (grant1),
        .out_valid (tag_out_valid),
        .out_id    (tag_out_id),
        .any_valid (tag_any_valid)
    );

    // Steer the cell result to the owner of the retiring tag.
    always_comb begin
        rsp0_valid = tag_out_valid && (tag_out_id == 1'b0);
        rsp1_valid = tag_out_valid && (tag_out_id == 1'b1);
        rsp_result = '0;
        if (rsp0_valid || rsp1_valid) begin
            rsp_result = A_mul_cell_result;
        end
    end

    assign busy = tag_any_valid;

endmodule

// File: tb/tb_cpu_mul_arbiter.sv
// Drives three arbiter builds (latency 1, 2, 3) with the same request
// stream; each build has its own behavioural multiplier cell and scoreboard.
module tb_cpu_mul_arbiter;

    localparam int unsigned N_INST = 3;

    typedef struct {
        logic        v0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic        v1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        r0;
        logic        r1;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] prod;
        int unsigned due;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        req0_valid;
    logic [31:0] req0_src1;
    logic [31:0] req0_src2;
    logic        req1_valid;
    logic [31:0] req1_src1;
    logic [31:0] req1_src2;

    logic        ready0_w [N_INST];
    logic        ready1_w [N_INST];
    logic [31:0] msrc1_w  [N_INST];
    logic [31:0] msrc2_w  [N_INST];
    logic [31:0] cell_w   [N_INST];
    logic        rsp0_w   [N_INST];
    logic        rsp1_w   [N_INST];
    logic [31:0] res_w    [N_INST];
    logic        busy_w   [N_INST];

    int unsigned checks;
    int unsigned errors;
    int unsigned cyc;
    exp_t        sb [N_INST][$];
    vec_t        tbl [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N_INST; g++) begin : g_inst
        localparam int unsigned L = g + 1;
        logic [31:0] cell_q [L];

        cpu_mul_arbiter #(
            .MUL_LATENCY (L),
            .DATA_W      (32)
        ) u_dut (
            .clk               (clk),
            .reset_n           (reset_n),
            .req0_valid        (req0_valid),
            .req0_ready        (ready0_w[g]),
            .req0_src1         (req0_src1),
            .req0_src2         (req0_src2),
            .req1_valid        (req1_valid),
            .req1_ready        (ready1_w[g]),
            .req1_src1         (req1_src1),
            .req1_src2         (req1_src2),
            .A_mul_src1        (msrc1_w[g]),
            .A_mul_src2        (msrc2_w[g]),
            .A_mul_cell_result (cell_w[g]),
            .rsp0_valid        (rsp0_w[g]),
            .rsp1_valid        (rsp1_w[g]),
            .rsp_result        (res_w[g]),
            .busy              (busy_w[g])
        );

        // Behavioural multiplier cell: L-stage pipeline sharing the reset.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < L; i++) cell_q[i] <= '0;
            end else begin
                cell_q[0] <= msrc1_w[g] * msrc2_w[g];
                for (int i = 1; i < L; i++) cell_q[i] <= cell_q[i-1];
            end
        end
        assign cell_w[g] = cell_q[L-1];
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL L%0d %s: got %0h expected %0h (cycle %0d)", inst + 1, name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                                input logic r0, input logic r1);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.b0 = b0;
        v.v1 = v1; v.a1 = a1; v.b1 = b1;
        v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        req0_valid = v.v0; req0_src1 = v.a0; req0_src2 = v.b0;
        req1_valid = v.v1; req1_src1 = v.a1; req1_src2 = v.b1;
    endtask

    // Called just after a falling edge with inputs applied; checks this
    // cycle's outputs, records issues, then advances one clock.
    task automatic cycle(input logic er0, input logic er1);
        #1;
        for (int i = 0; i < N_INST; i++) begin
            logic        e_v0;
            logic        e_v1;
            logic [31:0] e_res;
            logic [31:0] e_s1;
            logic [31:0] e_s2;
            exp_t        e;
            e_v0  = 1'b0;
            e_v1  = 1'b0;
            e_res = '0;
            chk("busy", i, {31'd0, busy_w[i]}, {31'd0, sb[i].size() != 0});
            if (sb[i].size() != 0 && sb[i][0].due == cyc) begin
                e = sb[i].pop_front();
                e_v0  = (e.id == 1'b0);
                e_v1  = (e.id == 1'b1);
                e_res = e.prod;
            end
            chk("rsp0_valid", i, {31'd0, rsp0_w[i]}, {31'd0, e_v0});
            chk("rsp1_valid", i, {31'd0, rsp1_w[i]}, {31'd0, e_v1});
            chk("rsp_result", i, res_w[i], e_res);
            chk("req0_ready", i, {31'd0, ready0_w[i]}, {31'd0, er0});
            chk("req1_ready", i, {31'd0, ready1_w[i]}, {31'd0, er1});
            e_s1 = er0 ? req0_src1 : (er1 ? req1_src1 : 32'd0);
            e_s2 = er0 ? req0_src2 : (er1 ? req1_src2 : 32'd0);
            chk("A_mul_src1", i, msrc1_w[i], e_s1);
            chk("A_mul_src2", i, msrc2_w[i], e_s2);
            if (req0_valid && ready0_w[i]) begin
                e.id = 1'b0; e.prod = req0_src1 * req0_src2; e.due = cyc + i + 1;
                sb[i].push_back(e);
            end
            if (req1_valid && ready1_w[i]) begin
                e.id = 1'b1; e.prod = req1_src1 * req1_src2; e.due = cyc + i + 1;
                sb[i].push_back(e);
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        reset_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));

        // Reset state, then release.
        @(negedge clk);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        reset_n = 1'b1;

        tbl.push_back(mk(1, 3, 5, 0, 0, 0, 1, 0));                   // lone req0
        tbl.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFF, 2, 0, 1));       // truncation
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 3, 1, 4, 5, 1, 0));                   // contention x4
        tbl.push_back(mk(1, 2, 3, 1, 4, 5, 0, 1));
        tbl.push_back(mk(1, 2, 3, 1, 4, 5, 1, 0));
        tbl.push_back(mk(1, 2, 3, 1, 4, 5, 0, 1));
        tbl.push_back(mk(1, 2, 3, 0, 0, 0, 1, 0));                   // held op completes
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0));                   // back-to-back
        tbl.push_back(mk(1, 2, 2, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3, 3, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 7, 6, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 9, 9, 1, 10, 10, 0, 1));                 // last was req0
        tbl.push_back(mk(1, 9, 9, 1, 11, 11, 1, 0));
        tbl.push_back(mk(1, 12, 12, 1, 11, 11, 0, 1));
        tbl.push_back(mk(1, 12, 12, 0, 0, 0, 1, 0));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k]);
            cycle(tbl[k].r0, tbl[k].r1);
        end

        // Reset with operations in flight; last grant before reset is req0.
        drive(mk(0, 0, 0, 1, 6, 6, 0, 0));
        cycle(1'b0, 1'b1);
        drive(mk(1, 5, 5, 0, 0, 0, 0, 0));
        cycle(1'b1, 1'b0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < N_INST; i++) begin
            chk("busy after reset", i, {31'd0, busy_w[i]}, 32'd0);
            chk("rsp0 after reset", i, {31'd0, rsp0_w[i]}, 32'd0);
            chk("rsp1 after reset", i, {31'd0, rsp1_w[i]}, 32'd0);
            chk("result after reset", i, res_w[i], 32'd0);
            sb[i].delete();
        end
        @(negedge clk);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        reset_n = 1'b1;
        drive(mk(1, 8, 8, 1, 9, 9, 0, 0));
        cycle(1'b1, 1'b0);
        drive(mk(1, 14, 14, 1, 9, 9, 0, 0));
        cycle(1'b0, 1'b1);
        drive(mk(1, 14, 14, 0, 0, 0, 0, 0));
        cycle(1'b1, 1'b0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0);

        for (int i = 0; i < N_INST; i++) begin
            chk("scoreboard drained", i, sb[i].size(), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
